// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - EX-side bundle for the iterative multiply/divide engine
//
// Purpose: groups the request, operand and result signals exchanged between
//          the EX stage and muldiv_unit.
// Signals:
//   start_i      request, held by EX until ready_o
//   op_i[1:0]    00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opdata1_i    multiplicand / dividend
//   opdata2_i    multiplier / divisor
//   annul_i      flush / exception cancel
//   result_hi_o  product high half / remainder
//   result_lo_o  product low half / quotient
//   ready_o      result valid (registered)
//   stallreq_o   pipeline stall request
// Modports: master = EX stage, slave = muldiv_unit.

interface muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] opdata1_i;
  logic [DATA_W-1:0] opdata2_i;
  logic              annul_i;
  logic [DATA_W-1:0] result_hi_o;
  logic [DATA_W-1:0] result_lo_o;
  logic              ready_o;
  logic              stallreq_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, annul_i,
    input  result_hi_o, result_lo_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
    output result_hi_o, result_lo_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - radix-2 iterative signed/unsigned multiply and divide engine
//
// Purpose: computes HI/LO for MULT/MULTU/DIV/DIVU one bit per clock
//          (DATA_W iterations), divide-by-zero answers 0/0 after one edge.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   muldiv_unit_if.slave (request, operands, annul, results, ready, stall)

module muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_RUN, S_DONE} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                is_div_q;
  logic                sign_pq_q;   // product/quotient negative (signed ops only)
  logic                sign_r_q;    // remainder negative (signed ops only)
  logic [DATA_W-1:0]   opb_q;       // multiplicand or divisor magnitude
  logic [2*DATA_W-1:0] acc_q;       // {hi, lo} working accumulator
  logic [2*DATA_W-1:0] acc_d;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                ready_q;

  // Operand magnitudes and signs at request time.
  logic              is_signed_in;
  logic              sign1, sign2;
  logic [DATA_W-1:0] abs1, abs2;

  assign is_signed_in = ~bus.op_i[0];
  assign sign1        = is_signed_in & bus.opdata1_i[DATA_W-1];
  assign sign2        = is_signed_in & bus.opdata2_i[DATA_W-1];
  assign abs1         = sign1 ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2         = sign2 ? -bus.opdata2_i : bus.opdata2_i;

  // One iteration of either algorithm. The W+1-bit sums keep the carry of the
  // multiply add and the bit shifted out of the remainder during divide.
  logic [DATA_W:0] mul_sum, rem_sh, diff;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh  = acc_q[2*DATA_W-1:DATA_W-1];
    diff    = rem_sh - {1'b0, opb_q};
    acc_d   = '0;
    if (is_div_q) begin
      if (diff[DATA_W]) acc_d = {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
      else              acc_d = {diff[DATA_W-1:0],   acc_q[DATA_W-2:0], 1'b1};
    end else begin
      acc_d = {mul_sum, acc_q[DATA_W-1:1]};
    end
  end

  // Sign fix-up applied to the final iteration's value.
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   fin_hi, fin_lo;

  always_comb begin
    prod_fix = sign_pq_q ? -acc_d : acc_d;
    if (is_div_q) begin
      fin_hi = sign_r_q  ? -acc_d[2*DATA_W-1:DATA_W] : acc_d[2*DATA_W-1:DATA_W];
      fin_lo = sign_pq_q ? -acc_d[DATA_W-1:0]        : acc_d[DATA_W-1:0];
    end else begin
      fin_hi = prod_fix[2*DATA_W-1:DATA_W];
      fin_lo = prod_fix[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      sign_pq_q <= 1'b0;
      sign_r_q  <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      ready_q   <= 1'b0;
    end else if (bus.annul_i && state_q != S_IDLE) begin
      // Flush wins over completion; results keep their last completed value.
      state_q <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            is_div_q  <= bus.op_i[1];
            sign_pq_q <= sign1 ^ sign2;
            sign_r_q  <= sign1;
            cnt_q     <= '0;
            if (bus.op_i[1]) begin
              opb_q <= abs2;
              acc_q <= {{DATA_W{1'b0}}, abs1};
            end else begin
              opb_q <= abs1;
              acc_q <= {{DATA_W{1'b0}}, abs2};
            end
            if (bus.op_i[1] && bus.opdata2_i == '0) state_q <= S_DIVZERO;
            else                                     state_q <= S_RUN;
          end
        end
        S_DIVZERO: begin
          hi_q    <= '0;
          lo_q    <= '0;
          ready_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            hi_q    <= fin_hi;
            lo_q    <= fin_lo;
            ready_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!bus.start_i) begin
            ready_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.result_hi_o = hi_q;
  assign bus.result_lo_o = lo_q;
  assign bus.ready_o     = ready_q;
  assign bus.stallreq_o  = bus.start_i & ~ready_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit

module tb_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_W(W)) mdu_if ();

  muldiv_unit #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mdu_if)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation from a falling edge, counts rising edges until ready_o,
  // optionally holds start_i in DONE, then releases and checks the return to IDLE.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int exp_edges, input int hold);
    int edges;
    @(negedge clk);
    mdu_if.start_i   = 1'b1;
    mdu_if.op_i      = op;
    mdu_if.opdata1_i = a;
    mdu_if.opdata2_i = b;
    #1;
    check_val({tag, "_stall_start"}, 64'(mdu_if.stallreq_o), 64'd1);
    edges = 0;
    while (!mdu_if.ready_o && edges < 200) begin
      @(negedge clk);
      edges++;
      // Operands may change after sampling without effect.
      mdu_if.opdata1_i = 32'h1234_5678;
      mdu_if.opdata2_i = 32'h0000_0003;
    end
    check_val({tag, "_ready"}, 64'(mdu_if.ready_o), 64'd1);
    check_val({tag, "_latency"}, 64'(edges - 1), 64'(exp_edges));
    check_val({tag, "_stall_done"}, 64'(mdu_if.stallreq_o), 64'd0);
    check_val({tag, "_hi"}, 64'(mdu_if.result_hi_o), 64'(exp_hi));
    check_val({tag, "_lo"}, 64'(mdu_if.result_lo_o), 64'(exp_lo));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val({tag, "_hold_ready"}, 64'(mdu_if.ready_o), 64'd1);
      check_val({tag, "_hold_hi"}, 64'(mdu_if.result_hi_o), 64'(exp_hi));
      check_val({tag, "_hold_lo"}, 64'(mdu_if.result_lo_o), 64'(exp_lo));
    end
    mdu_if.start_i = 1'b0;
    @(negedge clk);
    check_val({tag, "_idle_ready"}, 64'(mdu_if.ready_o), 64'd0);
    check_val({tag, "_idle_hi"}, 64'(mdu_if.result_hi_o), 64'(exp_hi));
    check_val({tag, "_idle_lo"}, 64'(mdu_if.result_lo_o), 64'(exp_lo));
  endtask

  initial begin
    int rose;
    rst              = 1'b1;
    mdu_if.start_i   = 1'b0;
    mdu_if.op_i      = 2'b00;
    mdu_if.opdata1_i = '0;
    mdu_if.opdata2_i = '0;
    mdu_if.annul_i   = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", 64'(mdu_if.ready_o), 64'd0);
    check_val("rst_hi", 64'(mdu_if.result_hi_o), 64'd0);
    check_val("rst_lo", 64'(mdu_if.result_lo_o), 64'd0);
    check_val("rst_stall", 64'(mdu_if.stallreq_o), 64'd0);
    rst = 1'b0;

    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32, 0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32, 0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, 0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32, 0);
    run_op("divu_zero", 2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 0);
    run_op("divu_3",    2'b11, 32'h8000_0000, 32'h0000_0003, 32'h0000_0002, 32'h2AAA_AAAA, 32, 3);

    // Annul at iteration 10: back to IDLE, results keep the DIVU result.
    @(negedge clk);
    mdu_if.start_i   = 1'b1;
    mdu_if.op_i      = 2'b00;
    mdu_if.opdata1_i = 32'h0000_0009;
    mdu_if.opdata2_i = 32'h0000_0009;
    repeat (10) @(negedge clk);
    mdu_if.annul_i = 1'b1;
    mdu_if.start_i = 1'b0;
    @(negedge clk);
    mdu_if.annul_i = 1'b0;
    check_val("annul_ready", 64'(mdu_if.ready_o), 64'd0);
    check_val("annul_hi", 64'(mdu_if.result_hi_o), 64'h2);
    check_val("annul_lo", 64'(mdu_if.result_lo_o), 64'h2AAA_AAAA);
    rose = 0;
    repeat (40) begin
      @(negedge clk);
      if (mdu_if.ready_o) rose = 1;
    end
    check_val("annul_no_ready", 64'(rose), 64'd0);
    check_val("annul_keep_lo", 64'(mdu_if.result_lo_o), 64'h2AAA_AAAA);
    run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 32, 0);

    // Reset mid-run clears results; a following DIV still works.
    @(negedge clk);
    mdu_if.start_i   = 1'b1;
    mdu_if.op_i      = 2'b11;
    mdu_if.opdata1_i = 32'd1000;
    mdu_if.opdata2_i = 32'd3;
    repeat (5) @(negedge clk);
    rst            = 1'b1;
    mdu_if.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_ready", 64'(mdu_if.ready_o), 64'd0);
    check_val("midrst_hi", 64'(mdu_if.result_hi_o), 64'd0);
    check_val("midrst_lo", 64'(mdu_if.result_lo_o), 64'd0);
    run_op("div_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 32, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
